// File: rtl/pc_ras_unit.sv
// Program counter with hold/inc/load/branch/call/return and a circular return-address stack.
// Latency 1 cycle; no backpressure, enable_i=0 freezes all state.
module pc_ras_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      STEP         = 1,
  parameter int unsigned      OFF_W        = 16,
  parameter int unsigned      RAS_DEPTH    = 8,
  localparam int unsigned     CNT_W        = $clog2(RAS_DEPTH + 1)
) (
  input  logic             clock_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [2:0]       mode_i,
  input  logic             cond_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [OFF_W-1:0] offset_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [CNT_W-1:0] ras_count_o,
  output logic             ras_empty_o,
  output logic             ras_full_o,
  output logic             ras_err_o
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  localparam logic [2:0] MODE_HOLD   = 3'b000;
  localparam logic [2:0] MODE_INC    = 3'b001;
  localparam logic [2:0] MODE_LOAD   = 3'b010;
  localparam logic [2:0] MODE_BRANCH = 3'b011;
  localparam logic [2:0] MODE_CALL   = 3'b100;
  localparam logic [2:0] MODE_RET    = 3'b101;

  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic             push;
  logic [WIDTH-1:0] pc_plus_step;
  logic [WIDTH-1:0] off_sext;
  logic [PTR_W-1:0] wp_inc;
  logic [PTR_W-1:0] wp_dec;
  logic             stack_empty;
  logic             stack_full;

  assign pc_plus_step = pc_q + STEP_W;
  assign off_sext     = WIDTH'($signed(offset_i));
  // Pointer wraps explicitly so non-power-of-two depths behave as mod D.
  assign wp_inc       = (wp_q == PTR_MAX) ? '0 : wp_q + PTR_W'(1);
  assign wp_dec       = (wp_q == '0) ? PTR_MAX : wp_q - PTR_W'(1);
  assign stack_empty  = (cnt_q == '0);
  assign stack_full   = (cnt_q == CNT_MAX);

  always_comb begin
    pc_d  = pc_q;
    wp_d  = wp_q;
    cnt_d = cnt_q;
    err_d = err_q;
    push  = 1'b0;
    if (enable_i) begin
      case (mode_i)
        MODE_HOLD: pc_d = pc_q;
        MODE_INC:  pc_d = pc_plus_step;
        MODE_LOAD: pc_d = d_i;
        MODE_BRANCH: begin
          // Displacement is taken from the current pc, not the incremented one.
          pc_d = cond_i ? (pc_q + off_sext) : pc_plus_step;
        end
        MODE_CALL: begin
          push = 1'b1;
          pc_d = d_i;
          wp_d = wp_inc;
          if (stack_full) begin
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        MODE_RET: begin
          if (stack_empty) begin
            pc_d  = pc_plus_step;
            err_d = 1'b1;
          end else begin
            pc_d  = ras_q[wp_dec];
            wp_d  = wp_dec;
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clock_i or posedge clear_i) begin
    if (clear_i) begin
      pc_q  <= RESET_VECTOR;
      wp_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // A push while full lands on the oldest slot, which is exactly where wp points.
  always_ff @(posedge clock_i or posedge clear_i) begin
    if (clear_i) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else if (push) begin
      ras_q[wp_q] <= pc_plus_step;
    end
  end

  assign pc_o        = pc_q;
  assign ras_count_o = cnt_q;
  assign ras_empty_o = stack_empty;
  assign ras_full_o  = stack_full;
  assign ras_err_o   = err_q;

endmodule
